spi_transaction_scheduler: RTL and testbench

Shares one `bidirectional_spi` core between two requesters, for example the PS register bridge and the pulse-sequencer configuration path. It applies round-robin arbitration and validates each request. It then sequences the core through start, done and an enforced chip-select gap, and routes the masked read-back data to the requester that owns the transaction. A watchdog aborts transactions that never complete.

---
 rtl/spi_transaction_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_spi_transaction_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_scheduler.sv
// spi_transaction_scheduler
// Shares one bidirectional SPI core between two requesters. Round-robin
// arbitration, request validation, start/done sequencing with an enforced
// chip-select gap, and masked read-back routed to the owning requester.
// Optional watchdog: define SPI_SCHED_TIMEOUT_EN to enable timeout/abort.
module spi_transaction_scheduler #(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 8,
  parameter int GAP_CYCLES            = 4,
  parameter int TIMEOUT_WIDTH         = 16
) (
  input  logic                             fabric_clk,
  input  logic                             reset_n,
  input  logic                             req0_valid,
  input  logic                             req1_valid,
  output logic                             req0_ready,
  output logic                             req1_ready,
  input  logic [TRANSACTION_LEN_WIDTH-1:0] req0_length,
  input  logic [TRANSACTION_LEN_WIDTH-1:0] req1_length,
  input  logic [DATA_WIDTH-1:0]            req0_data,
  input  logic [DATA_WIDTH-1:0]            req1_data,
  input  logic [DATA_WIDTH-1:0]            req0_rw_mask,
  input  logic [DATA_WIDTH-1:0]            req1_rw_mask,
  input  logic                             req0_cpol,
  input  logic                             req0_cpha,
  input  logic                             req1_cpol,
  input  logic                             req1_cpha,
  output logic                             rsp0_valid,
  output logic                             rsp1_valid,
  output logic [DATA_WIDTH-1:0]            rsp_read_data,
  output logic                             rsp_error,
  output logic                             spi_start,
  output logic                             spi_abort,
  output logic [TRANSACTION_LEN_WIDTH-1:0] spi_length,
  output logic [DATA_WIDTH-1:0]            spi_data,
  output logic [DATA_WIDTH-1:0]            spi_rw_mask,
  output logic                             spi_cpol,
  output logic                             spi_cpha,
  input  logic                             spi_done,
  input  logic [DATA_WIDTH-1:0]            spi_read_data,
  input  logic [TIMEOUT_WIDTH-1:0]         timeout_cycles,
  output logic                             busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [2:0]                       state;
  logic [2:0]                       state_next;
  logic                             last_grant;
  logic                             owner;
  logic                             winner;
  logic                             accept;
  logic                             req_ok;
  logic                             done_hit;
  logic                             timeout_hit;
  logic [GAP_W-1:0]                 gap_cnt;
  logic [TRANSACTION_LEN_WIDTH-1:0] sel_length;
  logic [DATA_WIDTH-1:0]            sel_data;
  logic [DATA_WIDTH-1:0]            sel_mask;
  logic                             sel_cpol;
  logic                             sel_cpha;

  // Round-robin pick: a lone requester wins, on contention the one not granted last wins
  always_comb begin
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else begin
      winner = req1_valid;
    end
  end

  // Handshake is only offered in IDLE, and never while reset is asserted
  assign req0_ready = reset_n && (state == IDLE) && req0_valid && !winner;
  assign req1_ready = reset_n && (state == IDLE) && req1_valid &&  winner;
  assign accept     = req0_ready || req1_ready;

  assign sel_length = winner ? req1_length  : req0_length;
  assign sel_data   = winner ? req1_data    : req0_data;
  assign sel_mask   = winner ? req1_rw_mask : req0_rw_mask;
  assign sel_cpol   = winner ? req1_cpol    : req0_cpol;
  assign sel_cpha   = winner ? req1_cpha    : req0_cpha;
  assign req_ok     = (sel_length != '0) && (32'(sel_length) <= 32'(DATA_WIDTH));

  assign done_hit = (state == WAIT) && spi_done;

`ifdef SPI_SCHED_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;

  assign timeout_hit = (state == WAIT) && !spi_done && (timeout_cycles != '0) &&
                       ((wait_cnt + TIMEOUT_WIDTH'(1)) == timeout_cycles);

  // Watchdog counts cycles spent in WAIT, cleared everywhere else
  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Abort pulse forces the core back to idle when the watchdog expires
  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_abort <= 1'b0;
    end else begin
      spi_abort <= timeout_hit;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout_cycles;
  assign timeout_hit    = 1'b0;
  assign spi_abort      = 1'b0;
`endif

  // Next-state selection for the transaction sequencer
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_ok ? ISSUE : RESP;
      ISSUE:   state_next = WAIT;
      WAIT:    if (done_hit || timeout_hit) state_next = RESP;
      RESP:    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Chip-select gap counter, runs only while in GAP
  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end else begin
      gap_cnt <= '0;
    end
  end

  // Registered core fields, start pulse, responses and grant bookkeeping
  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      spi_start     <= 1'b0;
      spi_length    <= '0;
      spi_data      <= '0;
      spi_rw_mask   <= '0;
      spi_cpol      <= 1'b0;
      spi_cpha      <= 1'b0;
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp_read_data <= '0;
      rsp_error     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      spi_start  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= (state_next != IDLE);
      if (accept) begin
        spi_length  <= sel_length;
        spi_data    <= sel_data;
        spi_rw_mask <= sel_mask;
        spi_cpol    <= sel_cpol;
        spi_cpha    <= sel_cpha;
        owner       <= winner;
        last_grant  <= winner;
        if (req_ok) begin
          spi_start <= 1'b1;
        end else begin
          rsp_error     <= 1'b1;
          rsp_read_data <= '0;
          rsp0_valid    <= !winner;
          rsp1_valid    <= winner;
        end
      end
      if (done_hit) begin
        rsp_read_data <= spi_read_data & ~spi_rw_mask;
        rsp_error     <= 1'b0;
        rsp0_valid    <= !owner;
        rsp1_valid    <= owner;
      end else if (timeout_hit) begin
        rsp_read_data <= '0;
        rsp_error     <= 1'b1;
        rsp0_valid    <= !owner;
        rsp1_valid    <= owner;
      end
    end
  end

endmodule

// File: tb/tb_spi_transaction_scheduler.sv
// tb_spi_transaction_scheduler
// Directed bench for spi_transaction_scheduler: arbitration, masked read-back,
// invalid lengths, chip-select gap, reset mid-transaction and, when
// SPI_SCHED_TIMEOUT_EN is defined, the watchdog.
module tb_spi_transaction_scheduler;

  logic        fabric_clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_length, req1_length;
  logic [31:0] req0_data, req1_data;
  logic [31:0] req0_rw_mask, req1_rw_mask;
  logic        req0_cpol, req0_cpha, req1_cpol, req1_cpha;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_read_data;
  logic        rsp_error;
  logic        spi_start, spi_abort;
  logic [7:0]  spi_length;
  logic [31:0] spi_data, spi_rw_mask;
  logic        spi_cpol, spi_cpha;
  logic        spi_done;
  logic [31:0] spi_read_data;
  logic [15:0] timeout_cycles;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  spi_transaction_scheduler dut (
    .fabric_clk     (fabric_clk),
    .reset_n        (reset_n),
    .req0_valid     (req0_valid),
    .req1_valid     (req1_valid),
    .req0_ready     (req0_ready),
    .req1_ready     (req1_ready),
    .req0_length    (req0_length),
    .req1_length    (req1_length),
    .req0_data      (req0_data),
    .req1_data      (req1_data),
    .req0_rw_mask   (req0_rw_mask),
    .req1_rw_mask   (req1_rw_mask),
    .req0_cpol      (req0_cpol),
    .req0_cpha      (req0_cpha),
    .req1_cpol      (req1_cpol),
    .req1_cpha      (req1_cpha),
    .rsp0_valid     (rsp0_valid),
    .rsp1_valid     (rsp1_valid),
    .rsp_read_data  (rsp_read_data),
    .rsp_error      (rsp_error),
    .spi_start      (spi_start),
    .spi_abort      (spi_abort),
    .spi_length     (spi_length),
    .spi_data       (spi_data),
    .spi_rw_mask    (spi_rw_mask),
    .spi_cpol       (spi_cpol),
    .spi_cpha       (spi_cpha),
    .spi_done       (spi_done),
    .spi_read_data  (spi_read_data),
    .timeout_cycles (timeout_cycles),
    .busy           (busy)
  );

  // Free-running fabric clock
  always #5 fabric_clk = ~fabric_clk;

  // Advance to just after the next falling edge, well away from the active edge
  task automatic tick();
    @(negedge fabric_clk);
    #1;
    cyc++;
  endtask

  // Drive one requester's request fields
  task automatic applyStimulus(input int who, input logic v, input logic [7:0] len,
                               input logic [31:0] data, input logic [31:0] mask,
                               input logic cpol, input logic cpha);
    if (who == 0) begin
      req0_valid = v; req0_length = len; req0_data = data;
      req0_rw_mask = mask; req0_cpol = cpol; req0_cpha = cpha;
    end else begin
      req1_valid = v; req1_length = len; req1_data = data;
      req1_rw_mask = mask; req1_cpol = cpol; req1_cpha = cpha;
    end
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Bounded wait for the scheduler to return to IDLE
  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic        acc;
    int          n;
    int          lastDone;
    logic        g;

    reset_n = 1'b0;
    applyStimulus(0, 1'b1, 8'd8, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    spi_done = 1'b0;
    spi_read_data = 32'h0;
    timeout_cycles = 16'd0;
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_start", {31'd0, spi_start}, 32'd0);
    checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd0);
    checkOutput("rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    checkOutput("rst_spi_data", spi_data, 32'd0);
    req0_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    $display("[TB] contention: both requesters held valid");
    applyStimulus(0, 1'b1, 8'd8, 32'h11000000, 32'h0000FFFF, 1'b0, 1'b1);
    applyStimulus(1, 1'b1, 8'd8, 32'h22000000, 32'hFF00FF00, 1'b1, 1'b1);
    #1;
    lastDone = -100;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        tick();
        n++;
      end
      checkOutput("cont_ready_seen", {31'd0, req0_ready | req1_ready}, 32'd1);
      checkOutput("cont_grant", {31'd0, req1_ready}, {31'd0, g});
      checkOutput("cont_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
      tick();
      checkOutput("cont_start", {31'd0, spi_start}, 32'd1);
      checkOutput("cont_spi_data", spi_data, g ? 32'h22000000 : 32'h11000000);
      if (k > 0) checkOutput("cont_gap", {31'd0, (cyc - lastDone - 1) >= 4}, 32'd1);
      tick();
      spi_done = 1'b1;
      spi_read_data = 32'hFFFFFFFF;
      lastDone = cyc;
      tick();
      spi_done = 1'b0;
      checkOutput("cont_rsp_valid", {30'd0, rsp1_valid, rsp0_valid},
                  g ? 32'd2 : 32'd1);
      checkOutput("cont_rsp_data", rsp_read_data, g ? 32'h00FF00FF : 32'hFFFF0000);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitIdle("cont_idle");

    $display("[TB] invalid lengths on requester 1");
    applyStimulus(1, 1'b1, 8'd0, 32'h77000000, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("inv0_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    checkOutput("inv0_no_start", {31'd0, spi_start}, 32'd0);
    checkOutput("inv0_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
    checkOutput("inv0_err", {31'd0, rsp_error}, 32'd1);
    checkOutput("inv0_data", rsp_read_data, 32'd0);
    req1_length = 8'd33;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("inv_gap_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    checkOutput("inv33_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    checkOutput("inv33_no_start", {31'd0, spi_start}, 32'd0);
    checkOutput("inv33_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
    checkOutput("inv33_err", {31'd0, rsp_error}, 32'd1);
    checkOutput("inv33_data", rsp_read_data, 32'd0);
    tick();
    checkOutput("inv33_no_start_late", {31'd0, spi_start}, 32'd0);
    waitIdle("inv_idle");

`ifdef SPI_SCHED_TIMEOUT_EN
    $display("[TB] watchdog with timeout_cycles=10");
    timeout_cycles = 16'd10;
    applyStimulus(0, 1'b1, 8'd8, 32'hC3000000, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("to_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    checkOutput("to_start", {31'd0, spi_start}, 32'd1);
    tick();
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      acc |= spi_abort;
      tick();
    end
    checkOutput("to_no_early_abort", {31'd0, acc}, 32'd0);
    checkOutput("to_abort", {31'd0, spi_abort}, 32'd1);
    checkOutput("to_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    checkOutput("to_err", {31'd0, rsp_error}, 32'd1);
    checkOutput("to_data", rsp_read_data, 32'd0);
    tick();
    checkOutput("to_abort_pulse", {31'd0, spi_abort}, 32'd0);
    waitIdle("to_idle");

    applyStimulus(0, 1'b1, 8'd8, 32'hC3000000, 32'h0, 1'b0, 1'b0);
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) tick();
    spi_done = 1'b1;
    spi_read_data = 32'hABCD1234;
    tick();
    spi_done = 1'b0;
    checkOutput("tod_no_abort", {31'd0, spi_abort}, 32'd0);
    checkOutput("tod_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    checkOutput("tod_err", {31'd0, rsp_error}, 32'd0);
    checkOutput("tod_data", rsp_read_data, 32'hABCD1234);
    timeout_cycles = 16'd0;
    waitIdle("tod_idle");
`endif

    $display("[TB] single transfer on requester 0");
    applyStimulus(0, 1'b1, 8'd16, 32'hA5C30000, 32'hFF000000, 1'b1, 1'b0);
    #1;
    checkOutput("st_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    checkOutput("st_start", {31'd0, spi_start}, 32'd1);
    checkOutput("st_len", {24'd0, spi_length}, 32'd16);
    checkOutput("st_data", spi_data, 32'hA5C30000);
    checkOutput("st_mask", spi_rw_mask, 32'hFF000000);
    checkOutput("st_mode", {30'd0, spi_cpol, spi_cpha}, 32'd2);
    checkOutput("st_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("st_start_pulse", {31'd0, spi_start}, 32'd0);
    spi_done = 1'b1;
    spi_read_data = 32'h12345678;
    tick();
    spi_done = 1'b0;
    checkOutput("st_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    checkOutput("st_rsp_data", rsp_read_data, 32'h00345678);
    checkOutput("st_rsp_err", {31'd0, rsp_error}, 32'd0);

    applyStimulus(1, 1'b1, 8'd8, 32'h5A000000, 32'h0, 1'b0, 1'b0);
    acc = 1'b0;
    g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc |= req1_ready;
      g   |= rsp0_valid;
    end
    checkOutput("gap_no_ready", {31'd0, acc}, 32'd0);
    checkOutput("gap_rsp_one_cycle", {31'd0, g}, 32'd0);
    tick();
    checkOutput("gap_ready_after", {31'd0, req1_ready}, 32'd1);

    $display("[TB] reset during WAIT");
    tick();
    checkOutput("rm_start", {31'd0, spi_start}, 32'd1);
    checkOutput("rm_data", spi_data, 32'h5A000000);
    tick();
    tick();
    reset_n = 1'b0;
    applyStimulus(0, 1'b1, 8'd8, 32'h3C000000, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("rm_busy", {31'd0, busy}, 32'd0);
    checkOutput("rm_strobes", {30'd0, spi_start, spi_abort}, 32'd0);
    checkOutput("rm_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    checkOutput("rm_rsp_data", rsp_read_data, 32'd0);
    checkOutput("rm_spi_data", spi_data, 32'd0);
    checkOutput("rm_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acc |= rsp1_valid | rsp0_valid;
    end
    checkOutput("rm_no_rsp", {31'd0, acc}, 32'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("rm_grant0_first", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("rm_post_start", {31'd0, spi_start}, 32'd1);
    checkOutput("rm_post_data", spi_data, 32'h3C000000);
    tick();
    spi_done = 1'b1;
    spi_read_data = 32'h000000FF;
    tick();
    spi_done = 1'b0;
    checkOutput("rm_post_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    checkOutput("rm_post_rsp_data", rsp_read_data, 32'h000000FF);
    waitIdle("end_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
